// File: rtl/alu_instr_sequencer.sv
// Fetch/decode/execute control sequencer for register-format ALU instructions.
// Drives the bus datapath strobes directly from the registered state, latched fields and counter.
module alu_instr_sequencer #(
    parameter int NUM_REGS   = 16,
    parameter int REG_SEL_W  = 4,
    parameter int ALU_LAT    = 1,
    parameter int MULDIV_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [31:0]         ir_q,
    input  logic                mem_rdy,
    output logic [NUM_REGS-1:0] reg_out_sel,
    output logic [NUM_REGS-1:0] reg_in_sel,
    output logic [12:0]         alu_op,
    output logic                PCout,
    output logic                PCin,
    output logic                IncPC,
    output logic                MARin,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                LOin,
    output logic                HIin,
    output logic                busy,
    output logic                done,
    output logic                illegal
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_T4   = 4'd5;
    localparam logic [3:0] S_T5   = 4'd6;
    localparam logic [3:0] S_T6   = 4'd7;
    localparam logic [3:0] S_DONE = 4'd8;

    localparam logic [5:0] ALU_LAST    = 6'(ALU_LAT - 1);
    localparam logic [5:0] MULDIV_LAST = 6'(MULDIV_LAT - 1);

    logic [3:0]           state_q, state_d;
    logic [5:0]           cnt_q, cnt_d;
    logic [12:0]          op_q;
    logic [REG_SEL_W-1:0] ra_q, rb_q, rc_q;
    logic                 illegal_q;

    logic [12:0]          decOp;
    logic                 decLegal, decMulDiv;
    logic [REG_SEL_W-1:0] irRa, irRb, irRc;
    logic                 mulDivOp, useRbOp, lastCycle;
    logic                 unused_ir_bits;

    function automatic logic [NUM_REGS-1:0] regSel(input logic [REG_SEL_W-1:0] idx);
        logic [NUM_REGS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(idx) == i) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [12:0] aluDecode(input logic [4:0] opc);
        logic [12:0] v;
        v = '0;
        case (opc)
            5'b00011: v[2]  = 1'b1;
            5'b00100: v[3]  = 1'b1;
            5'b00101: v[0]  = 1'b1;
            5'b00110: v[1]  = 1'b1;
            5'b00111: v[9]  = 1'b1;
            5'b01000: v[10] = 1'b1;
            5'b01001: v[6]  = 1'b1;
            5'b01010: v[7]  = 1'b1;
            5'b01011: v[8]  = 1'b1;
            5'b01111: v[5]  = 1'b1;
            5'b10000: v[4]  = 1'b1;
            5'b10001: v[11] = 1'b1;
            5'b10010: v[12] = 1'b1;
            default:  v     = '0;
        endcase
        return v;
    endfunction

    assign irRa           = ir_q[26 -: REG_SEL_W];
    assign irRb           = ir_q[22 -: REG_SEL_W];
    assign irRc           = ir_q[18 -: REG_SEL_W];
    assign unused_ir_bits = ^ir_q[14:0];
    assign decOp          = aluDecode(ir_q[31:27]);
    assign decLegal       = |decOp;
    assign decMulDiv      = decOp[4] | decOp[5];
    assign mulDivOp       = op_q[4] | op_q[5];
    assign useRbOp        = mulDivOp | op_q[11] | op_q[12];
    assign lastCycle      = (cnt_q == (mulDivOp ? MULDIV_LAST : ALU_LAST));

    // The counter doubles as a first-cycle marker in T1 and as the step timer in T4.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_T0;
            S_T0: begin
                state_d = S_T1;
                cnt_d   = '0;
            end
            S_T1: begin
                if (mem_rdy) begin
                    state_d = S_T2;
                    cnt_d   = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_T2: state_d = S_T3;
            S_T3: begin
                state_d = decLegal ? S_T4 : S_DONE;
                cnt_d   = '0;
            end
            S_T4: begin
                if (lastCycle) begin
                    state_d = S_T5;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_T5:    state_d = mulDivOp ? S_T6 : S_DONE;
            S_T6:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            ra_q      <= '0;
            rb_q      <= '0;
            rc_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_T3) begin
                op_q      <= decOp;
                ra_q      <= irRa;
                rb_q      <= irRb;
                rc_q      <= irRc;
                illegal_q <= ~decLegal;
            end
        end
    end

    always_comb begin
        reg_out_sel = '0;
        reg_in_sel  = '0;
        alu_op      = '0;
        PCout       = 1'b0;
        PCin        = 1'b0;
        IncPC       = 1'b0;
        MARin       = 1'b0;
        Read        = 1'b0;
        MDRin       = 1'b0;
        MDRout      = 1'b0;
        IRin        = 1'b0;
        Yin         = 1'b0;
        Zin         = 1'b0;
        Zlowout     = 1'b0;
        Zhighout    = 1'b0;
        LOin        = 1'b0;
        HIin        = 1'b0;
        busy        = (state_q != S_IDLE);
        done        = 1'b0;
        illegal     = 1'b0;
        case (state_q)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = (cnt_q == 6'd0);
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                if (decLegal) begin
                    Yin         = 1'b1;
                    reg_out_sel = regSel(decMulDiv ? irRa : irRb);
                end
            end
            S_T4: begin
                reg_out_sel = regSel(useRbOp ? rb_q : rc_q);
                alu_op      = op_q;
                Zin         = lastCycle;
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (mulDivOp) LOin = 1'b1;
                else          reg_in_sel = regSel(ra_q);
            end
            S_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
            end
            S_DONE: begin
                done    = 1'b1;
                illegal = illegal_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Scoreboard bench: each instruction pushes its hand-derived per-cycle output trace,
// and a negedge monitor pops one entry for every busy cycle.
module tb_alu_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, mem_rdy;
    logic [31:0] ir_q;
    logic [15:0] reg_out_sel, reg_in_sel;
    logic [12:0] alu_op;
    logic        PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
    logic        Yin, Zin, Zlowout, Zhighout, LOin, HIin, busy, done, illegal;

    localparam logic [13:0] S_PCOUT  = 14'd1 << 13;
    localparam logic [13:0] S_PCIN   = 14'd1 << 12;
    localparam logic [13:0] S_INCPC  = 14'd1 << 11;
    localparam logic [13:0] S_MARIN  = 14'd1 << 10;
    localparam logic [13:0] S_READ   = 14'd1 << 9;
    localparam logic [13:0] S_MDRIN  = 14'd1 << 8;
    localparam logic [13:0] S_MDROUT = 14'd1 << 7;
    localparam logic [13:0] S_IRIN   = 14'd1 << 6;
    localparam logic [13:0] S_YIN    = 14'd1 << 5;
    localparam logic [13:0] S_ZIN    = 14'd1 << 4;
    localparam logic [13:0] S_ZLOW   = 14'd1 << 3;
    localparam logic [13:0] S_ZHIGH  = 14'd1 << 2;
    localparam logic [13:0] S_LOIN   = 14'd1 << 1;
    localparam logic [13:0] S_HIIN   = 14'd1 << 0;

    logic [61:0] obsVec;
    logic [61:0] expV;
    logic [61:0] expQ[$];
    int          total = 0;
    int          bad   = 0;
    bit          monOn = 1'b0;

    always #5 clk = ~clk;

    alu_instr_sequencer #(
        .NUM_REGS(16), .REG_SEL_W(4), .ALU_LAT(1), .MULDIV_LAT(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .ir_q(ir_q), .mem_rdy(mem_rdy),
        .reg_out_sel(reg_out_sel), .reg_in_sel(reg_in_sel), .alu_op(alu_op),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .Read(Read),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .Zlowout(Zlowout), .Zhighout(Zhighout), .LOin(LOin), .HIin(HIin),
        .busy(busy), .done(done), .illegal(illegal)
    );

    assign obsVec = {reg_out_sel, reg_in_sel, alu_op,
                     PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
                     Yin, Zin, Zlowout, Zhighout, LOin, HIin, busy, done, illegal};

    function automatic logic [61:0] mk(input logic [15:0] ro, input logic [15:0] ri,
                                       input logic [12:0] op, input logic [13:0] st,
                                       input logic dn, input logic il);
        return {ro, ri, op, st, 1'b1, dn, il};
    endfunction

    task automatic pushInstr(input logic [15:0] t3Sel, input logic [15:0] t4Sel,
                             input logic [15:0] inSel, input logic [12:0] op,
                             input int lat, input bit mulDiv, input bit illOp,
                             input int waitCyc, input bit cutAtT4);
        expQ.push_back(mk(16'h0, 16'h0, 13'h0, S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 1'b0, 1'b0));
        expQ.push_back(mk(16'h0, 16'h0, 13'h0, S_ZLOW | S_PCIN | S_READ | S_MDRIN, 1'b0, 1'b0));
        for (int i = 0; i < waitCyc; i++)
            expQ.push_back(mk(16'h0, 16'h0, 13'h0, S_ZLOW | S_READ | S_MDRIN, 1'b0, 1'b0));
        expQ.push_back(mk(16'h0, 16'h0, 13'h0, S_MDROUT | S_IRIN, 1'b0, 1'b0));
        if (illOp) begin
            expQ.push_back(mk(16'h0, 16'h0, 13'h0, 14'h0, 1'b0, 1'b0));
            expQ.push_back(mk(16'h0, 16'h0, 13'h0, 14'h0, 1'b1, 1'b1));
            return;
        end
        expQ.push_back(mk(t3Sel, 16'h0, 13'h0, S_YIN, 1'b0, 1'b0));
        for (int i = 0; i < lat; i++)
            expQ.push_back(mk(t4Sel, 16'h0, op, (i == lat - 1) ? S_ZIN : 14'h0, 1'b0, 1'b0));
        if (cutAtT4) return;
        if (mulDiv) begin
            expQ.push_back(mk(16'h0, 16'h0, 13'h0, S_ZLOW | S_LOIN, 1'b0, 1'b0));
            expQ.push_back(mk(16'h0, 16'h0, 13'h0, S_ZHIGH | S_HIIN, 1'b0, 1'b0));
        end else begin
            expQ.push_back(mk(16'h0, inSel, 13'h0, S_ZLOW, 1'b0, 1'b0));
        end
        expQ.push_back(mk(16'h0, 16'h0, 13'h0, 14'h0, 1'b1, 1'b0));
    endtask

    // Drives one start pulse; c counts rising edges after the start edge.
    task automatic applyStimulus(input logic [31:0] ir, input int waitCyc,
                                 input int startMidAt, input int resetAt, input int runCycles);
        @(posedge clk);
        #1;
        ir_q    = ir;
        start   = 1'b1;
        mem_rdy = (waitCyc == 0);
        for (int c = 0; c < runCycles; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) start = 1'b0;
            if (c == 1 + waitCyc) mem_rdy = 1'b1;
            if (c == startMidAt) start = 1'b1;
            if (c == startMidAt + 1) start = 1'b0;
            if (c == resetAt) reset = 1'b1;
            if (c == resetAt + 1) reset = 1'b0;
        end
        mem_rdy = 1'b1;
    endtask

    task automatic checkOutput(input string name);
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL %s leftover_entries got=%0d want=0", name, expQ.size());
            expQ.delete();
        end
    endtask

    always @(negedge clk) begin
        if (monOn) begin
            total++;
            if (busy === 1'b1) begin
                if (expQ.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL unexpected_busy got=%h want=idle", obsVec);
                end else begin
                    expV = expQ.pop_front();
                    if (obsVec !== expV) begin
                        bad++;
                        $display("[TB] FAIL cycle_outputs t=%0t got=%h want=%h", $time, obsVec, expV);
                    end
                end
            end else if (obsVec !== 62'h0) begin
                bad++;
                $display("[TB] FAIL idle_outputs t=%0t got=%h want=0", $time, obsVec);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got=timeout want=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        mem_rdy = 1'b1;
        ir_q    = 32'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total++;
        if (obsVec !== 62'h0) begin
            bad++;
            $display("[TB] FAIL reset_state got=%h want=0", obsVec);
        end
        monOn = 1'b1;

        $display("[TB] SUB R4,R3,R7");
        pushInstr(16'h0008, 16'h0080, 16'h0010, 13'h0008, 1, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus(32'h221B8000, 0, -1, -1, 14);
        checkOutput("sub_basic");

        $display("[TB] SUB with 3 memory wait cycles");
        pushInstr(16'h0008, 16'h0080, 16'h0010, 13'h0008, 1, 1'b0, 1'b0, 3, 1'b0);
        applyStimulus(32'h221B8000, 3, -1, -1, 16);
        checkOutput("sub_wait");

        $display("[TB] MUL R3,R7");
        pushInstr(16'h0008, 16'h0080, 16'h0000, 13'h0010, 4, 1'b1, 1'b0, 0, 1'b0);
        applyStimulus(32'h81B80000, 0, -1, -1, 18);
        checkOutput("mul");

        $display("[TB] illegal opcode 11111");
        pushInstr(16'h0, 16'h0, 16'h0, 13'h0, 0, 1'b0, 1'b1, 0, 1'b0);
        applyStimulus(32'hF8000000, 0, -1, -1, 12);
        checkOutput("illegal");

        $display("[TB] reset during T4");
        pushInstr(16'h0008, 16'h0080, 16'h0010, 13'h0008, 1, 1'b0, 1'b0, 0, 1'b1);
        applyStimulus(32'h221B8000, 0, -1, 4, 10);
        checkOutput("reset_abort");
        pushInstr(16'h0008, 16'h0080, 16'h0010, 13'h0008, 1, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus(32'h221B8000, 0, -1, -1, 14);
        checkOutput("after_reset");

        $display("[TB] start pulsed during T2");
        pushInstr(16'h0008, 16'h0080, 16'h0010, 13'h0008, 1, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus(32'h221B8000, 0, 2, -1, 16);
        checkOutput("start_ignored");

        $display("[TB] NEG R5,R9");
        pushInstr(16'h0200, 16'h0200, 16'h0020, 13'h0800, 1, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus({5'b10001, 4'd5, 4'd9, 4'd0, 15'd0}, 0, -1, -1, 14);
        checkOutput("neg");

        $display("[TB] ROL R1,R2,R15");
        pushInstr(16'h0004, 16'h8000, 16'h0002, 13'h0400, 1, 1'b0, 1'b0, 1, 1'b0);
        applyStimulus({5'b01000, 4'd1, 4'd2, 4'd15, 15'd0}, 1, -1, -1, 14);
        checkOutput("rol");

        $display("[TB] DIV R2,R12");
        pushInstr(16'h0004, 16'h1000, 16'h0000, 13'h0020, 4, 1'b1, 1'b0, 0, 1'b0);
        applyStimulus({5'b01111, 4'd2, 4'd12, 4'd0, 15'd0}, 0, -1, -1, 18);
        checkOutput("div");

        monOn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
